// File: rtl/req_ack_responder_pkg.sv
// +--------------------------------------------------------------------+
// | req_ack_pkg : shared types and helpers for req_ack_responder       |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package req_ack_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    COOL = 2'd3
  } state_t;

  function automatic logic [LAT_W-1:0] clamp_lat(
    input logic [LAT_W-1:0] lat,
    input logic [LAT_W-1:0] lo,
    input logic [LAT_W-1:0] hi
  );
    logic [LAT_W-1:0] v;
    v = lat;
    if (lat < lo) begin
      v = lo;
    end else if (lat > hi) begin
      v = hi;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/req_ack_responder_if.sv
// +--------------------------------------------------------------------+
// | req_ack_responder_if : initiator-facing handshake and status bus   |
// | Revision             : 1.0                                         |
// +--------------------------------------------------------------------+
`default_nettype none

interface req_ack_responder_if #(
  parameter int CNT_W = 8
);
  import req_ack_pkg::*;

  logic             req;
  logic             en;
  logic [LAT_W-1:0] lat_cfg;
  logic             ack;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] txn_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output req, en, lat_cfg,
    input  ack, busy, overrun, txn_cnt, drop_cnt
  );

  modport slave (
    input  req, en, lat_cfg,
    output ack, busy, overrun, txn_cnt, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/req_ack_responder_edge_det.sv
// +--------------------------------------------------------------------+
// | edge_det : one-cycle delayed rise/fall detector                    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic r_q;
  logic r_armed;

  // r_armed masks the first cycle after reset so a level already high is not an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_q     <= d;
      r_armed <= 1'b1;
    end
  end

  assign rise = r_armed & d & ~r_q;
  assign fall = r_armed & ~d & r_q;

endmodule

`default_nettype wire

// File: rtl/req_ack_responder.sv
// +--------------------------------------------------------------------+
// | req_ack_responder : answers each req rise with a fixed ack burst   |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int LAT_MIN = 1,
  parameter int LAT_MAX = 5,
  parameter int ACK_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  req_ack_responder_if.slave bus
);

  localparam logic [1:0]       c_st_idle  = IDLE;
  localparam logic [1:0]       c_st_wait  = WAIT;
  localparam logic [1:0]       c_st_ack   = ACK;
  localparam logic [1:0]       c_st_cool  = COOL;
  localparam logic [LAT_W-1:0] c_lat_min  = LAT_W'(LAT_MIN);
  localparam logic [LAT_W-1:0] c_lat_max  = LAT_W'(LAT_MAX);
  localparam logic [2:0]       c_ack_last = 3'(ACK_LEN - 1);

  logic             w_rise;
  logic             w_fall_en;
  logic             w_unused_req_fall;
  logic             w_unused_en_rise;

  logic [1:0]       r_state;
  logic [LAT_W-1:0] r_lat_ctr;
  logic [2:0]       r_ack_ctr;
  logic             r_ack;
  logic             r_overrun;
  logic [CNT_W-1:0] r_txn_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [1:0]       w_state_nxt;
  logic [LAT_W-1:0] w_lat_nxt;
  logic [2:0]       w_ack_ctr_nxt;
  logic [LAT_W-1:0] w_lat;
  logic             w_done;
  logic             w_drop;

  edge_det u_req_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.req),
    .rise  (w_rise),
    .fall  (w_unused_req_fall)
  );

  edge_det u_en_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.en),
    .rise  (w_unused_en_rise),
    .fall  (w_fall_en)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_nxt     = r_lat_ctr;
    w_ack_ctr_nxt = r_ack_ctr;
    w_done        = 1'b0;
    w_lat         = clamp_lat(bus.lat_cfg, c_lat_min, c_lat_max);
    case (r_state)
      c_st_idle: begin
        if (w_rise && bus.en) begin
          w_lat_nxt = w_lat - 1'b1;
          if (w_lat == LAT_W'(1)) begin
            w_state_nxt   = c_st_ack;
            w_ack_ctr_nxt = c_ack_last;
          end else begin
            w_state_nxt = c_st_wait;
          end
        end
      end
      c_st_wait: begin
        // Leaving on 1 makes the WAIT phase L-1 cycles, so ack lands L cycles after the rise
        if (w_fall_en) begin
          w_state_nxt = c_st_idle;
        end else if (r_lat_ctr == LAT_W'(1)) begin
          w_state_nxt   = c_st_ack;
          w_ack_ctr_nxt = c_ack_last;
        end else begin
          w_lat_nxt = r_lat_ctr - 1'b1;
        end
      end
      c_st_ack: begin
        if (w_fall_en) begin
          w_state_nxt = c_st_idle;
        end else if (r_ack_ctr == 3'd0) begin
          w_state_nxt = c_st_cool;
          w_done      = 1'b1;
        end else begin
          w_ack_ctr_nxt = r_ack_ctr - 1'b1;
        end
      end
      c_st_cool: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
    w_drop = w_rise && ((r_state != c_st_idle) || !bus.en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_lat_ctr  <= '0;
      r_ack_ctr  <= '0;
      r_ack      <= 1'b0;
      r_overrun  <= 1'b0;
      r_txn_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_ctr <= w_lat_nxt;
      r_ack_ctr <= w_ack_ctr_nxt;
      r_ack     <= (w_state_nxt == c_st_ack);
      if (w_done) begin
        r_txn_cnt <= r_txn_cnt + 1'b1;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.ack      = r_ack;
  assign bus.busy     = (r_state != c_st_idle);
  assign bus.overrun  = r_overrun;
  assign bus.txn_cnt  = r_txn_cnt;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_req_ack_responder.sv
// +--------------------------------------------------------------------+
// | tb_req_ack_responder : vectors, corner sequences, random vs model  |
// | Revision             : 1.0                                         |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_req_ack_responder;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 5;
  localparam int ACK_LEN = 3;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  req_ack_responder_if #(.CNT_W(CNT_W)) bus_if ();

  req_ack_responder #(
    .LAT_MIN (LAT_MIN),
    .LAT_MAX (LAT_MAX),
    .ACK_LEN (ACK_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: an accepted rise at edge e occupies edges e..e+L+ACK_LEN-1,
  // with ack visible after edges e+L-1 .. e+L+ACK_LEN-2.
  int         n = 0;
  bit         m_active, m_prev_req, m_prev_en, m_armed, m_overrun;
  int         m_e, m_L;
  logic [7:0] m_txn, m_drop;
  int         ack_run = 0;

  typedef struct {
    logic       req;
    logic [3:0] lat;
    logic       ack;
    logic       busy;
    logic [7:0] txn;
  } vec_t;

  vec_t vt [22];

  function automatic int clamp_ref(input int v);
    return (v < LAT_MIN) ? LAT_MIN : ((v > LAT_MAX) ? LAT_MAX : v);
  endfunction

  function automatic bit in_window(input int idx);
    return m_active && (idx >= m_e) && (idx <= m_e + m_L + ACK_LEN - 1);
  endfunction

  function automatic bit exp_ack(input int idx);
    return m_active && (idx >= m_e + m_L - 1) && (idx <= m_e + m_L + ACK_LEN - 2);
  endfunction

  task automatic model_edge();
    bit rise, fall, nonidle;
    if (!rst_n) begin
      m_active = 0; m_overrun = 0; m_txn = '0; m_drop = '0;
      m_prev_req = 0; m_prev_en = 0; m_armed = 0;
    end else begin
      rise    = m_armed && bus_if.req && !m_prev_req;
      fall    = m_prev_en && !bus_if.en;
      nonidle = in_window(n - 1);
      if (nonidle && fall) begin
        m_active = 0;
      end else if (nonidle && (n == m_e + m_L + ACK_LEN - 1)) begin
        m_txn = m_txn + 8'd1;
      end
      if (rise) begin
        if (!nonidle && bus_if.en) begin
          m_active = 1;
          m_e      = n;
          m_L      = clamp_ref(int'(bus_if.lat_cfg));
        end else begin
          m_overrun = 1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
      end
      m_prev_req = bus_if.req;
      m_prev_en  = bus_if.en;
      m_armed    = 1;
    end
    n++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n - 1);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("ack",      int'(bus_if.ack),      int'(exp_ack(n - 1)));
    chk("busy",     int'(bus_if.busy),     int'(in_window(n - 1)));
    chk("overrun",  int'(bus_if.overrun),  int'(m_overrun));
    chk("txn_cnt",  int'(bus_if.txn_cnt),  int'(m_txn));
    chk("drop_cnt", int'(bus_if.drop_cnt), int'(m_drop));
    ack_run = bus_if.ack ? ack_run + 1 : 0;
    chk("ack_run_le_len", int'(ack_run <= ACK_LEN), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus_if.req     = 1'b0;
    bus_if.en      = 1'b1;
    bus_if.lat_cfg = 4'd3;

    // lat_cfg=3, then clamp low (0 -> 1), then clamp high (9 -> 5)
    vt[0]  = '{1'b0, 4'd3, 1'b0, 1'b0, 8'd0};
    vt[1]  = '{1'b1, 4'd3, 1'b0, 1'b1, 8'd0};
    vt[2]  = '{1'b1, 4'd3, 1'b0, 1'b1, 8'd0};
    vt[3]  = '{1'b1, 4'd3, 1'b1, 1'b1, 8'd0};
    vt[4]  = '{1'b0, 4'd3, 1'b1, 1'b1, 8'd0};
    vt[5]  = '{1'b0, 4'd3, 1'b1, 1'b1, 8'd0};
    vt[6]  = '{1'b0, 4'd3, 1'b0, 1'b1, 8'd1};
    vt[7]  = '{1'b0, 4'd3, 1'b0, 1'b0, 8'd1};
    vt[8]  = '{1'b1, 4'd0, 1'b1, 1'b1, 8'd1};
    vt[9]  = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd1};
    vt[10] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd1};
    vt[11] = '{1'b0, 4'd0, 1'b0, 1'b1, 8'd2};
    vt[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 8'd2};
    vt[13] = '{1'b1, 4'd9, 1'b0, 1'b1, 8'd2};
    vt[14] = '{1'b0, 4'd9, 1'b0, 1'b1, 8'd2};
    vt[15] = '{1'b0, 4'd9, 1'b0, 1'b1, 8'd2};
    vt[16] = '{1'b0, 4'd9, 1'b0, 1'b1, 8'd2};
    vt[17] = '{1'b0, 4'd9, 1'b1, 1'b1, 8'd2};
    vt[18] = '{1'b0, 4'd9, 1'b1, 1'b1, 8'd2};
    vt[19] = '{1'b0, 4'd9, 1'b1, 1'b1, 8'd2};
    vt[20] = '{1'b0, 4'd9, 1'b0, 1'b1, 8'd3};
    vt[21] = '{1'b0, 4'd9, 1'b0, 1'b0, 8'd3};

    do_reset();
    chk("reset_ack",  int'(bus_if.ack),      0);
    chk("reset_busy", int'(bus_if.busy),     0);
    chk("reset_txn",  int'(bus_if.txn_cnt),  0);
    chk("reset_drop", int'(bus_if.drop_cnt), 0);

    for (int i = 0; i < 22; i++) begin
      bus_if.req     = vt[i].req;
      bus_if.lat_cfg = vt[i].lat;
      tick();
      chk($sformatf("vec%0d_ack", i),  int'(bus_if.ack),     int'(vt[i].ack));
      chk($sformatf("vec%0d_busy", i), int'(bus_if.busy),    int'(vt[i].busy));
      chk($sformatf("vec%0d_txn", i),  int'(bus_if.txn_cnt), int'(vt[i].txn));
    end

    // Second rise while waiting is dropped; first burst still completes
    bus_if.lat_cfg = 4'd3;
    bus_if.req = 1'b1; tick();
    bus_if.req = 1'b0; tick();
    bus_if.req = 1'b1; tick();
    chk("drop_overrun", int'(bus_if.overrun),  1);
    chk("drop_cnt_1",   int'(bus_if.drop_cnt), 1);
    bus_if.req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("burst_intact_txn", int'(bus_if.txn_cnt), 4);

    // Abort during second ack cycle
    bus_if.lat_cfg = 4'd0;
    bus_if.req = 1'b1; tick();
    bus_if.req = 1'b0; tick();
    chk("abort_pre_ack", int'(bus_if.ack), 1);
    bus_if.en = 1'b0; tick();
    chk("abort_ack",  int'(bus_if.ack),     0);
    chk("abort_busy", int'(bus_if.busy),    0);
    chk("abort_txn",  int'(bus_if.txn_cnt), 4);
    bus_if.en = 1'b1; tick(); tick();

    // Reset during ACK with req held high afterwards
    bus_if.lat_cfg = 4'd3;
    bus_if.req = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_ack", int'(bus_if.ack), 1);
    rst_n = 1'b0; tick();
    chk("rst_ack",     int'(bus_if.ack),      0);
    chk("rst_busy",    int'(bus_if.busy),     0);
    chk("rst_overrun", int'(bus_if.overrun),  0);
    chk("rst_txn",     int'(bus_if.txn_cnt),  0);
    chk("rst_drop",    int'(bus_if.drop_cnt), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_req_no_ack", int'(bus_if.busy), 0);
    end
    bus_if.req = 1'b0; tick();
    bus_if.req = 1'b1; tick(); tick(); tick();
    chk("rerise_ack", int'(bus_if.ack), 1);
    bus_if.req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // 256 back-to-back transactions wrap the counter
    do_reset();
    bus_if.lat_cfg = 4'd0;
    bus_if.req = 1'b0; tick();
    for (int k = 0; k < 256; k++) begin
      bus_if.req = 1'b1; tick();
      bus_if.req = 1'b0;
      for (int j = 0; j < 1 + ACK_LEN; j++) tick();
    end
    chk("wrap_txn",     int'(bus_if.txn_cnt), 0);
    chk("wrap_overrun", int'(bus_if.overrun), 0);

    // Randomised traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      bus_if.en      = ($urandom_range(0, 24) != 0);
      bus_if.lat_cfg = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) bus_if.req = ~bus_if.req;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
